// File: rtl/dump_pkg.sv
// ---------------------------------------------------------------------------
// dump_pkg
// Shared definitions for the sample dump readout path:
//   - top-level and byte-sender state encodings
//   - bit positions of the fields inside a 32-bit sample record
//   - default frame separator byte
//   - record checksum function (also used by the sampler side)
// ---------------------------------------------------------------------------
package dump_pkg;

  // Framer states. TX stands for the whole send/ack/drain handshake,
  // which lives inside uart_byte_sender.
  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_RD_REQ  = 4'd1;
  localparam logic [3:0] ST_RD_WAIT = 4'd2;
  localparam logic [3:0] ST_CHECK   = 4'd3;
  localparam logic [3:0] ST_TX      = 4'd4;
  localparam logic [3:0] ST_NEXT    = 4'd5;
  localparam logic [3:0] ST_FINISH  = 4'd6;

  // Byte sender handshake states
  localparam logic [1:0] TXS_IDLE  = 2'd0;
  localparam logic [1:0] TXS_SEND  = 2'd1;
  localparam logic [1:0] TXS_ACK   = 2'd2;
  localparam logic [1:0] TXS_DRAIN = 2'd3;

  // Record layout: v = [31:20], i = [19:8], csum = [7:1], flag = [0]
  localparam int V_MSB    = 31;
  localparam int V_LSB    = 20;
  localparam int I_MSB    = 19;
  localparam int I_LSB    = 8;
  localparam int CSUM_MSB = 7;
  localparam int CSUM_LSB = 1;
  localparam int FLAG_BIT = 0;

  localparam logic [7:0] SEP_BYTE = 8'h0A;

  // Sum of the three bytes covering v and i, taken at 8 bits and
  // truncated to the 7-bit checksum width.
  function automatic logic [6:0] record_csum(input logic [31:0] rec);
    logic [11:0] v;
    logic [11:0] i;
    v = rec[V_MSB:V_LSB];
    i = rec[I_MSB:I_LSB];
    return 7'(v[11:4] + {v[3:0], i[11:8]} + i[7:0]);
  endfunction

endpackage

// File: rtl/uart_byte_sender.sv
// ---------------------------------------------------------------------------
// uart_byte_sender
// Hands one byte to a UART transmitter using its busy line as handshake:
// wait idle, strobe, wait busy, wait idle again.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   load       - capture byte_in and start a new handshake
//   byte_in    - byte to send
//   tx_byte    - registered byte towards the UART, held until drained
//   tx_dv      - one-cycle strobe for tx_byte
//   tx_active  - UART busy
//   sent       - high in the cycle the UART finished with the byte
// ---------------------------------------------------------------------------
module uart_byte_sender (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic [7:0] tx_byte,
  output logic       tx_dv,
  input  logic       tx_active,
  output logic       sent
);
  import dump_pkg::*;

  logic [1:0] state_q, state_d;
  logic [7:0] byte_q, byte_d;
  logic       dv_q, dv_d;

  // Next-state logic. A load always restarts the handshake; the framer
  // only issues one while this block is idle or finishing its drain.
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    dv_d    = 1'b0;
    if (load) begin
      byte_d  = byte_in;
      state_d = TXS_SEND;
    end else begin
      case (state_q)
        TXS_SEND: begin
          if (!tx_active) begin
            dv_d    = 1'b1;
            state_d = TXS_ACK;
          end
        end
        TXS_ACK: begin
          if (tx_active) state_d = TXS_DRAIN;
        end
        TXS_DRAIN: begin
          if (!tx_active) state_d = TXS_IDLE;
        end
        default: state_d = TXS_IDLE;
      endcase
    end
  end

  // State, byte and strobe registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TXS_IDLE;
      byte_q  <= 8'h00;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      dv_q    <= dv_d;
    end
  end

  assign tx_byte = byte_q;
  assign tx_dv   = dv_q;
  assign sent    = (state_q == TXS_DRAIN) && !tx_active;

endmodule

// File: rtl/sample_dump_framer.sv
// ---------------------------------------------------------------------------
// sample_dump_framer
// Walks SDRAM from address 0, reads 32-bit sample records, checks flag and
// checksum, and sends each valid record as a 6-byte frame to the UART.
// Stops on the first record with flag 0, after LAST_ADDR, or on abort at a
// frame boundary.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   start, abort        - begin a dump / end it after the current frame
//   cmd_*               - SDRAM controller read command port
//   data_out(_ready)    - SDRAM read data and its valid pulse
//   tx_byte/tx_dv       - byte strobe towards the UART
//   tx_active           - UART busy
//   busy, done          - dump in progress / one-cycle end pulse
//   records_sent        - frames fully transmitted in this/last dump
//   csum_errors         - records with a bad checksum (saturating)
// ---------------------------------------------------------------------------
module sample_dump_framer #(
  parameter int                ADDR_W    = 23,
  parameter logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}},
  parameter logic [7:0]        SEP_BYTE  = dump_pkg::SEP_BYTE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              cmd_ready,
  output logic              cmd_enable,
  output logic              cmd_wr,
  output logic [ADDR_W-1:0] cmd_address,
  input  logic [31:0]       data_out,
  input  logic              data_out_ready,
  output logic [7:0]        tx_byte,
  output logic              tx_dv,
  input  logic              tx_active,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   records_sent,
  output logic [15:0]       csum_errors
);
  import dump_pkg::*;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [3:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       rec_q, rec_d;
  logic [2:0]        idx_q, idx_d;
  logic [ADDR_W:0]   sent_q, sent_d;
  logic [15:0]       err_q, err_d;
  logic              abort_q, abort_d;
  logic              load;
  logic [7:0]        byte_in;
  logic              tx_sent;

  // Main sequencer. An abort seen anywhere during the dump is remembered
  // and only acted on in NEXT, so frames are never cut short.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rec_d   = rec_q;
    idx_d   = idx_q;
    sent_d  = sent_q;
    err_d   = err_q;
    abort_d = abort_q | abort;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          sent_d  = '0;
          err_d   = 16'h0000;
          addr_d  = '0;
          abort_d = abort;
          state_d = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (cmd_ready) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (data_out_ready) begin
          rec_d   = data_out;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!rec_q[FLAG_BIT]) begin
          state_d = ST_FINISH;
        end else begin
          if (rec_q[CSUM_MSB:CSUM_LSB] != record_csum(rec_q) && err_q != 16'hFFFF)
            err_d = err_q + 16'd1;
          idx_d   = 3'd0;
          load    = 1'b1;
          state_d = ST_TX;
        end
      end
      ST_TX: begin
        // Next byte is loaded in the same cycle the previous one drains
        if (tx_sent) begin
          if (idx_q < 3'd5) begin
            idx_d = idx_q + 3'd1;
            load  = 1'b1;
          end else begin
            state_d = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        sent_d = sent_q + CNT_ONE;
        if (addr_q == LAST_ADDR || abort_q || abort) begin
          state_d = ST_FINISH;
        end else begin
          addr_d  = addr_q + ADDR_ONE;
          state_d = ST_RD_REQ;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Frame byte selection for the byte about to be loaded
  always_comb begin
    case (idx_d)
      3'd0:    byte_in = SEP_BYTE;
      3'd1:    byte_in = {4'h0, rec_q[31:28]};
      3'd2:    byte_in = rec_q[27:20];
      3'd3:    byte_in = {4'h0, rec_q[19:16]};
      3'd4:    byte_in = rec_q[15:8];
      default: byte_in = {1'b0, rec_q[7:1]};
    endcase
  end

  // Sequencer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rec_q   <= 32'h0;
      idx_q   <= 3'd0;
      sent_q  <= '0;
      err_q   <= 16'h0000;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rec_q   <= rec_d;
      idx_q   <= idx_d;
      sent_q  <= sent_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  uart_byte_sender u_sender (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .byte_in   (byte_in),
    .tx_byte   (tx_byte),
    .tx_dv     (tx_dv),
    .tx_active (tx_active),
    .sent      (tx_sent)
  );

  assign cmd_enable   = (state_q == ST_RD_REQ);
  assign cmd_wr       = 1'b0;
  assign cmd_address  = addr_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_FINISH);
  assign records_sent = sent_q;
  assign csum_errors  = err_q;

endmodule

// File: tb/tb_sample_dump_framer.sv
// ---------------------------------------------------------------------------
// tb_sample_dump_framer
// Scoreboard bench: scenarios push hand-computed frame bytes into a queue,
// a monitor pops and compares on every tx_dv. SDRAM and UART are modelled
// by small responder processes.
// ---------------------------------------------------------------------------
module tb_sample_dump_framer;

  localparam int ADDR_W = 23;

  // Hand-computed records and their frames
  localparam logic [31:0] R0    = 32'h12345639;
  localparam logic [31:0] R1    = 32'hABCDEFCF;
  localparam logic [31:0] R1BAD = 32'hABCDEFCD;
  localparam logic [31:0] R2    = 32'h00000001;
  localparam logic [31:0] R3    = 32'hFFFFFFFB;
  localparam logic [31:0] F0    = 32'h12345638;
  localparam logic [47:0] FR0    = 48'h0A_01_23_04_56_1C;
  localparam logic [47:0] FR1    = 48'h0A_0A_BC_0D_EF_67;
  localparam logic [47:0] FR1BAD = 48'h0A_0A_BC_0D_EF_66;
  localparam logic [47:0] FR2    = 48'h0A_00_00_00_00_00;
  localparam logic [47:0] FR3    = 48'h0A_0F_FF_0F_FF_7D;

  logic              clk, rst, start, abort;
  logic              cmd_ready, cmd_enable, cmd_wr;
  logic [ADDR_W-1:0] cmd_address;
  logic [31:0]       data_out;
  logic              data_out_ready;
  logic [7:0]        tx_byte;
  logic              tx_dv, tx_active, busy, done;
  logic [ADDR_W:0]   records_sent;
  logic [15:0]       csum_errors;

  sample_dump_framer #(.ADDR_W(ADDR_W), .LAST_ADDR(23'd3)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cmd_ready(cmd_ready), .cmd_enable(cmd_enable), .cmd_wr(cmd_wr),
    .cmd_address(cmd_address), .data_out(data_out),
    .data_out_ready(data_out_ready), .tx_byte(tx_byte), .tx_dv(tx_dv),
    .tx_active(tx_active), .busy(busy), .done(done),
    .records_sent(records_sent), .csum_errors(csum_errors)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:3];
  logic [7:0]  expQ [$];
  int checks = 0, errors = 0;
  int cyc = 0, txCount = 0, doneCount = 0, reads = 0;
  int lastReadAddr = 0, rdyCyc = 0, doneCyc = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic pushFrame(input logic [47:0] f);
    for (int k = 5; k >= 0; k--) expQ.push_back(f[k*8 +: 8]);
  endtask

  // Monitor: samples 1 time unit after each rising edge
  initial begin
    logic [7:0] expByte;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (data_out_ready && !rst) rdyCyc = cyc;
      if (done) begin
        doneCount++;
        doneCyc = cyc;
      end
      if (tx_dv) begin
        txCount++;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL tx_byte: unexpected byte %0h, expected none", tx_byte);
        end else begin
          expByte = expQ.pop_front();
          checkOutput("tx_byte", {24'h0, tx_byte}, {24'h0, expByte});
        end
      end
    end
  end

  // SDRAM responder: fixed read latency, cmd_ready low every third cycle
  initial begin
    int pending = 0, readyCnt = 0;
    logic [1:0] pendAddr = 2'd0;
    cmd_ready = 1'b0;
    data_out = 32'h0;
    data_out_ready = 1'b0;
    forever begin
      @(negedge clk);
      data_out_ready = 1'b0;
      if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          data_out = mem[pendAddr];
          data_out_ready = 1'b1;
        end
      end
      readyCnt++;
      cmd_ready = (readyCnt % 3) != 0;
      if (cmd_enable && cmd_ready && !rst) begin
        reads++;
        pendAddr = cmd_address[1:0];
        lastReadAddr = int'(cmd_address);
        pending = 6;
      end
    end
  end

  // UART model: goes busy two cycles after a strobe, for five cycles
  initial begin
    int pre = 0, act = 0;
    tx_active = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_dv) begin
        pre = 2;
      end else if (pre > 0) begin
        pre--;
        if (pre == 0) begin
          tx_active = 1'b1;
          act = 5;
        end
      end else if (act > 0) begin
        act--;
        if (act == 0) tx_active = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] m0, m1, m2, m3, input logic withAbort);
    mem[0] = m0; mem[1] = m1; mem[2] = m2; mem[3] = m3;
    @(negedge clk);
    start = 1'b1;
    abort = withAbort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic waitDone(input int base);
    int n = 0;
    while (doneCount == base && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (doneCount == base) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no done, expected a done pulse");
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic waitTx(input int target);
    int n = 0;
    while (txCount < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (txCount < target) begin
      checks++;
      errors++;
      $display("[TB] FAIL tx_timeout: got %0d bytes, expected %0d", txCount, target);
    end
  endtask

  // Watchdog
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int txB, dnB, rdB;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    mem[0] = 32'h0; mem[1] = 32'h0; mem[2] = 32'h0; mem[3] = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_cmd_enable", {31'h0, cmd_enable}, 32'h0);
    checkOutput("rst_cmd_wr", {31'h0, cmd_wr}, 32'h0);
    checkOutput("rst_tx_dv", {31'h0, tx_dv}, 32'h0);
    checkOutput("rst_done", {31'h0, done}, 32'h0);
    checkOutput("rst_records", {8'h0, records_sent}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] three valid records then flag 0");
    txB = txCount; dnB = doneCount;
    pushFrame(FR0); pushFrame(FR1); pushFrame(FR2);
    applyStimulus(R0, R1, R2, F0, 1'b0);
    checkOutput("busy_after_start", {31'h0, busy}, 32'h1);
    waitDone(dnB);
    checkOutput("t1_records", {8'h0, records_sent}, 32'd3);
    checkOutput("t1_csum", {16'h0, csum_errors}, 32'd0);
    checkOutput("t1_bytes", txCount - txB, 32'd18);
    checkOutput("t1_done_count", doneCount - dnB, 32'd1);
    checkOutput("t1_queue", expQ.size(), 32'd0);
    checkOutput("t1_busy", {31'h0, busy}, 32'h0);

    $display("[TB] first record has flag 0");
    txB = txCount; dnB = doneCount; rdB = reads;
    applyStimulus(F0, R1, R2, R3, 1'b0);
    waitDone(dnB);
    checkOutput("t2_records", {8'h0, records_sent}, 32'd0);
    checkOutput("t2_bytes", txCount - txB, 32'd0);
    checkOutput("t2_reads", reads - rdB, 32'd1);
    checkOutput("t2_done_latency", doneCyc - rdyCyc, 32'd1);

    $display("[TB] corrupt checksum on record 1");
    txB = txCount; dnB = doneCount;
    pushFrame(FR0); pushFrame(FR1BAD);
    applyStimulus(R0, R1BAD, F0, R3, 1'b0);
    waitDone(dnB);
    checkOutput("t3_csum", {16'h0, csum_errors}, 32'd1);
    checkOutput("t3_records", {8'h0, records_sent}, 32'd2);
    checkOutput("t3_bytes", txCount - txB, 32'd12);
    checkOutput("t3_queue", expQ.size(), 32'd0);

    $display("[TB] abort during byte 2 of frame 1");
    txB = txCount; dnB = doneCount; rdB = reads;
    pushFrame(FR0); pushFrame(FR1);
    applyStimulus(R0, R1, R2, R3, 1'b0);
    waitTx(txB + 9);
    abort = 1'b1;
    waitDone(dnB);
    abort = 1'b0;
    checkOutput("t4_records", {8'h0, records_sent}, 32'd2);
    checkOutput("t4_reads", reads - rdB, 32'd2);
    checkOutput("t4_last_addr", lastReadAddr, 32'd1);
    checkOutput("t4_bytes", txCount - txB, 32'd12);
    checkOutput("t4_queue", expQ.size(), 32'd0);

    $display("[TB] run to LAST_ADDR with a start while busy");
    txB = txCount; dnB = doneCount; rdB = reads;
    pushFrame(FR0); pushFrame(FR1); pushFrame(FR2); pushFrame(FR3);
    applyStimulus(R0, R1, R2, R3, 1'b0);
    waitTx(txB + 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(dnB);
    checkOutput("t5_records", {8'h0, records_sent}, 32'd4);
    checkOutput("t5_bytes", txCount - txB, 32'd24);
    checkOutput("t5_reads", reads - rdB, 32'd4);
    checkOutput("t5_last_addr", lastReadAddr, 32'd3);
    checkOutput("t5_done_count", doneCount - dnB, 32'd1);
    checkOutput("t5_queue", expQ.size(), 32'd0);

    $display("[TB] start together with abort");
    txB = txCount; dnB = doneCount;
    pushFrame(FR0);
    applyStimulus(R0, R1, R2, R3, 1'b1);
    waitDone(dnB);
    checkOutput("t7_records", {8'h0, records_sent}, 32'd1);
    checkOutput("t7_bytes", txCount - txB, 32'd6);
    checkOutput("t7_queue", expQ.size(), 32'd0);

    $display("[TB] reset while waiting for read data");
    txB = txCount; dnB = doneCount; rdB = reads;
    applyStimulus(R1, R1, R1, R1, 1'b0);
    begin
      int n = 0;
      while (reads == rdB && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    checkOutput("t6_read_issued", reads - rdB, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("t6_busy", {31'h0, busy}, 32'h0);
    checkOutput("t6_cmd_enable", {31'h0, cmd_enable}, 32'h0);
    checkOutput("t6_records", {8'h0, records_sent}, 32'd0);
    checkOutput("t6_csum", {16'h0, csum_errors}, 32'd0);
    checkOutput("t6_tx_byte", {24'h0, tx_byte}, 32'h0);
    checkOutput("t6_bytes", txCount - txB, 32'd0);
    checkOutput("t6_done_count", doneCount - dnB, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
